// File: rtl/z80_bus_responder.sv
// Z80 bus target: decodes memory, I/O and INTA cycles, stretches them with nWAIT and bridges them to a req/ack backend.
// Optional macro Z80_M1_WAIT_EN adds one extra wait cycle after opcode-fetch reads.
module z80_bus_responder #(
    parameter bit IO_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic        bk_req,
    output logic        bk_we,
    output logic        bk_io,
    output logic [15:0] bk_addr,
    output logic [7:0]  bk_wdata,
    input  logic [7:0]  bk_rdata,
    input  logic        bk_ack,
    input  logic [7:0]  int_vector,
    output logic        inta
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

`ifdef Z80_M1_WAIT_EN
    typedef enum logic [1:0] {IDLE, REQ, EXTRA, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic            bk_req_q, bk_req_d;
    logic            bk_we_q, bk_we_d;
    logic            bk_io_q, bk_io_d;
    logic [AW-1:0]   bk_addr_q, bk_addr_d;
    logic [DW-1:0]   bk_wdata_q, bk_wdata_d;
    logic [DW-1:0]   d_out_q, d_out_d;
    logic            d_oe_q, d_oe_d;
    logic            inta_q, inta_d;
    logic            cyc_inta_q, cyc_inta_d;
`ifdef Z80_M1_WAIT_EN
    logic            m1_q, m1_d;
`endif

    logic dec_inta, dec_mrd, dec_mwr, dec_iord, dec_iowr, dec_xfer;
    logic strobe_act, wait_c;

    // Cycle decode straight from the strobes; refresh never qualifies a memory cycle
    always_comb begin
        dec_inta = !nIORQ && !nM1;
        dec_mrd  = !nMREQ && !nRD && nRFSH;
        dec_mwr  = !nMREQ && !nWR && nRFSH;
        dec_iord = IO_EN && !nIORQ && !nRD && nM1;
        dec_iowr = IO_EN && !nIORQ && !nWR && nM1;
        dec_xfer = !dec_inta && (dec_mrd || dec_mwr || dec_iord || dec_iowr);
    end

    // Strobe pair of the cycle in flight is still held low by the CPU
    always_comb begin
        if (cyc_inta_q) begin
            strobe_act = !nIORQ;
        end else begin
            strobe_act = (bk_io_q ? !nIORQ : !nMREQ) && (bk_we_q ? !nWR : !nRD);
        end
    end

    always_comb begin
        wait_c = (state_q == IDLE && dec_xfer) || (state_q == REQ);
`ifdef Z80_M1_WAIT_EN
        wait_c = wait_c || (state_q == EXTRA);
`endif
    end

    assign nWAIT = !nRESET || !wait_c;

    always_comb begin
        state_d    = state_q;
        bk_req_d   = bk_req_q;
        bk_we_d    = bk_we_q;
        bk_io_d    = bk_io_q;
        bk_addr_d  = bk_addr_q;
        bk_wdata_d = bk_wdata_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        inta_d     = 1'b0;
        cyc_inta_d = cyc_inta_q;
`ifdef Z80_M1_WAIT_EN
        m1_d       = m1_q;
`endif
        case (state_q)
            IDLE: begin
                if (dec_inta) begin
                    d_out_d    = int_vector;
                    d_oe_d     = 1'b1;
                    inta_d     = 1'b1;
                    cyc_inta_d = 1'b1;
                    state_d    = DONE;
                end else if (dec_xfer) begin
                    bk_req_d   = 1'b1;
                    bk_addr_d  = A;
                    cyc_inta_d = 1'b0;
                    state_d    = REQ;
`ifdef Z80_M1_WAIT_EN
                    m1_d       = dec_mrd && !nM1;
`endif
                    if (dec_mrd) begin
                        bk_we_d = 1'b0;
                        bk_io_d = 1'b0;
                    end else if (dec_mwr) begin
                        bk_we_d    = 1'b1;
                        bk_io_d    = 1'b0;
                        bk_wdata_d = D_IN;
                    end else if (dec_iord) begin
                        bk_we_d = 1'b0;
                        bk_io_d = 1'b1;
                    end else begin
                        bk_we_d    = 1'b1;
                        bk_io_d    = 1'b1;
                        bk_wdata_d = D_IN;
                    end
                end
            end
            REQ: begin
                // The backend access always completes; an abandoned CPU cycle just drops the data
                if (bk_ack) begin
                    bk_req_d = 1'b0;
                    if (!strobe_act) begin
                        state_d = IDLE;
                    end else begin
                        if (!bk_we_q) begin
                            d_out_d = bk_rdata;
                            d_oe_d  = 1'b1;
                        end
`ifdef Z80_M1_WAIT_EN
                        state_d = m1_q ? EXTRA : DONE;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef Z80_M1_WAIT_EN
            EXTRA: begin
                state_d = DONE;
            end
`endif
            DONE: begin
                if (!strobe_act) begin
                    d_oe_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            bk_req_q   <= 1'b0;
            bk_we_q    <= 1'b0;
            bk_io_q    <= 1'b0;
            bk_addr_q  <= '0;
            bk_wdata_q <= '0;
            d_out_q    <= '0;
            d_oe_q     <= 1'b0;
            inta_q     <= 1'b0;
            cyc_inta_q <= 1'b0;
`ifdef Z80_M1_WAIT_EN
            m1_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bk_req_q   <= bk_req_d;
            bk_we_q    <= bk_we_d;
            bk_io_q    <= bk_io_d;
            bk_addr_q  <= bk_addr_d;
            bk_wdata_q <= bk_wdata_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            inta_q     <= inta_d;
            cyc_inta_q <= cyc_inta_d;
`ifdef Z80_M1_WAIT_EN
            m1_q       <= m1_d;
`endif
        end
    end

    assign bk_req   = bk_req_q;
    assign bk_we    = bk_we_q;
    assign bk_io    = bk_io_q;
    assign bk_addr  = bk_addr_q;
    assign bk_wdata = bk_wdata_q;
    assign D_OUT    = d_out_q;
    assign D_OE     = d_oe_q;
    assign inta     = inta_q;

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Bus-side responder for the tv80s Z80 core. It is the target end of the Z80 bus, complementary to the CPU-side initiator.
- Decodes memory, I/O and interrupt-acknowledge cycles from the Z80 strobes and forwards them to a req/ack backend (RAM, ROM or peripherals).
- Stretches each cycle with nWAIT until the backend acknowledges, and drives read data or the IM2 vector back to the CPU.
- Used in unit benches and as the CPU-to-memory bridge in the system.

Parameters:
- IO_EN, 1, when 0 the block ignores all I/O read/write cycles (no backend request, no wait, D_OE stays 0).

Ports:
- CLK  in  1  CPU clock, same edge as the tv80s core.
- nRESET  in  1  asynchronous active-low reset.
- A  in  16  CPU address bus.
- D_IN  in  8  data from the CPU (write data).
- D_OUT  out  8  data to the CPU.
- D_OE  out  1  drive enable for D_OUT onto the shared bus.
- nM1  in  1  opcode fetch / INTA qualifier.
- nMREQ  in  1  memory request strobe.
- nIORQ  in  1  I/O request strobe.
- nRD  in  1  read strobe.
- nWR  in  1  write strobe.
- nRFSH  in  1  refresh strobe.
- nWAIT  out  1  wait request to the CPU, active low.
- bk_req  out  1  backend request; held until acknowledged.
- bk_we  out  1  1 = write, 0 = read.
- bk_io  out  1  1 = I/O space, 0 = memory space.
- bk_addr  out  16  latched address.
- bk_wdata  out  8  latched write data.
- bk_rdata  in  8  backend read data; valid with bk_ack.
- bk_ack  in  1  one-cycle backend acknowledge.
- int_vector  in  8  IM2 vector returned on interrupt acknowledge.
- inta  out  1  one-cycle pulse on each interrupt acknowledge.

Behaviour:
- Reset (asynchronous, nRESET low): state IDLE; nWAIT=1, D_OE=0, D_OUT=0, bk_req=0, bk_we=0, bk_io=0, bk_addr=0, bk_wdata=0, inta=0. A reset in mid-cycle drops bk_req immediately and abandons the transaction; the backend must tolerate the abandoned request.
- Cycle decode, evaluated in IDLE only, highest priority first:
  - INTA: !nIORQ & !nM1.
  - MRD: !nMREQ & !nRD & nRFSH.
  - MWR: !nMREQ & !nWR.
  - IORD: !nIORQ & !nRD & nM1.
  - IOWR: !nIORQ & !nWR & nM1.
- Refresh cycles (!nRFSH & !nMREQ) are never decoded.
- States: IDLE, REQ, EXTRA (optional feature only), DONE.
- IDLE -> REQ on a decoded MRD/MWR/IORD/IOWR at a rising CLK. At that edge the block latches bk_addr=A, bk_wdata=D_IN (writes only), bk_we and bk_io, and sets bk_req=1.
- REQ:
  - bk_req held at 1.
  - On a sampled bk_ack=1: bk_req=0; for reads, D_OUT=bk_rdata and D_OE=1; next state DONE.
  - bk_ack is ignored in every other state.
- IDLE with INTA decoded: D_OUT=int_vector, D_OE=1, inta=1 for exactly one cycle; next state DONE. No backend access, no wait states.
- nWAIT is combinational and equals NOT(decoded non-INTA cycle in IDLE OR state==REQ OR state==EXTRA).
  - It goes low in the same cycle the strobes qualify.
  - It goes high only once D_OUT is valid.
  - Minimum stretch is 1 wait cycle (ack in the first REQ cycle).
- DONE:
  - D_OE stays asserted while the cycle's strobes stay low.
  - When the relevant strobe pair deasserts (nRD or nWR high, or nMREQ/nIORQ high), D_OE=0 and the state returns to IDLE.
  - D_OUT keeps its last value.
- Aborted cycle (strobes rise while in REQ): the request is still completed on bk_ack; read data is discarded, D_OE stays 0, and the state goes directly to IDLE.
- Back-to-back cycles: a new cycle is decoded only from IDLE, so there is at least one IDLE cycle between transactions. The Z80 strobe timing guarantees this.
- Simultaneous MREQ and IORQ is not possible in legal Z80 timing; if it occurs, the priority order above resolves it.

Optional Feature:
- Macro: Z80_M1_WAIT_EN.
- Defined: after bk_ack on an MRD with !nM1 (opcode fetch latched at decode), the block spends one cycle in EXTRA. nWAIT stays low and D_OUT is already valid; then it moves to DONE. This models slow opcode-fetch memory.
- Undefined: the EXTRA state does not exist; M1 fetches behave exactly like other memory reads.

Test Plan:
- Memory read: CPU reads 0x1234, backend acks with 0xA5 two cycles after bk_req -> bk_addr=0x1234, bk_we=0, bk_io=0, nWAIT low for 2 cycles, D_OUT=0xA5 with D_OE=1 until nRD rises.
- Memory write: CPU writes 0x5A to 0x8000, ack in the first REQ cycle -> bk_we=1, bk_wdata=0x5A, one wait cycle, D_OE never asserts.
- I/O: OUT (0xFE),0x07 then IN from 0x00FE with rdata 0x1F -> bk_io=1 for both, bk_addr=0x00FE, CPU register receives 0x1F. With IO_EN=0 -> no bk_req and nWAIT stays 1.
- Interrupt: IM2 with int_vector=0xE0 and nINT pulsed -> inta is a single-cycle pulse, D_OUT=0xE0, no wait, no bk_req.
- Refresh and abort: a refresh cycle produces no bk_req. Strobes released during REQ, then ack -> state IDLE, D_OE=0.
- Reset mid-REQ: nRESET low while bk_req=1 -> bk_req, D_OE and inta drop asynchronously and nWAIT=1. After release, a fetch from 0x0000 runs normally. With Z80_M1_WAIT_EN defined, that fetch shows one extra nWAIT-low cycle.
